// File: rtl/pop_timing_pkg.sv
// Shared timing definitions for the pulsed-optical-pumping (POP) Ramsey cycle.
// Holds the phase encoding, the tick period and the default phase lengths.
package pop_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PUMP  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_MW1   = 3'd3,
        ST_FREE  = 3'd4,
        ST_MW2   = 3'd5,
        ST_PROBE = 3'd6
    } pop_state_t;

    // One tick of the 2.5 MHz internal oscillator.
    localparam int unsigned TICK_NS = 400;

    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_PUMP_LEN   = 2500;
    localparam int unsigned DEF_WAIT_LEN   = 25;
    localparam int unsigned DEF_MW1_LEN    = 50;
    localparam int unsigned DEF_FREE_LEN   = 250;
    localparam int unsigned DEF_MW2_LEN    = 50;
    localparam int unsigned DEF_PROBE_LEN  = 500;
    localparam int unsigned DEF_SAMPLE_DLY = 25;
    localparam int unsigned DEF_SAMPLE_LEN = 250;

endpackage

// File: rtl/pop_cycle_sequencer.sv
// POP Ramsey cycle generator: pump, wait, MW pi/2, free precession, MW pi/2, probe.
// Gate outputs are registered from the next state so each one lines up exactly with its phase.
module pop_cycle_sequencer
    import pop_timing_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned PUMP_LEN   = DEF_PUMP_LEN,
    parameter int unsigned WAIT_LEN   = DEF_WAIT_LEN,
    parameter int unsigned MW1_LEN    = DEF_MW1_LEN,
    parameter int unsigned FREE_LEN   = DEF_FREE_LEN,
    parameter int unsigned MW2_LEN    = DEF_MW2_LEN,
    parameter int unsigned PROBE_LEN  = DEF_PROBE_LEN,
    parameter int unsigned SAMPLE_DLY = DEF_SAMPLE_DLY,
    parameter int unsigned SAMPLE_LEN = DEF_SAMPLE_LEN
) (
    input  logic        clock_2_5M,
    input  logic        reset_n,
    input  logic        enable,
    output logic        pump,
    output logic        probe,
    output logic        MW,
    output logic        sample,
    output logic        busy,
    output logic        cycle_start,
    output logic [15:0] cycle_count
);

    localparam int unsigned LEN_MAX = (1 << CNT_W) - 1;

    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("pop_cycle_sequencer: CNT_W must be in 1..31");
    end
    if (PUMP_LEN < 1 || WAIT_LEN < 1 || MW1_LEN < 1 || FREE_LEN < 1 ||
        MW2_LEN < 1 || PROBE_LEN < 1 || SAMPLE_LEN < 1) begin : g_bad_len_min
        $error("pop_cycle_sequencer: every phase length must be >= 1");
    end
    if (PUMP_LEN > LEN_MAX || WAIT_LEN > LEN_MAX || MW1_LEN > LEN_MAX || FREE_LEN > LEN_MAX ||
        MW2_LEN > LEN_MAX || PROBE_LEN > LEN_MAX) begin : g_bad_len_max
        $error("pop_cycle_sequencer: phase length does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] PUMP_LAST  = CNT_W'(PUMP_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_LEN - 1);
    localparam logic [CNT_W-1:0] MW1_LAST   = CNT_W'(MW1_LEN - 1);
    localparam logic [CNT_W-1:0] FREE_LAST  = CNT_W'(FREE_LEN - 1);
    localparam logic [CNT_W-1:0] MW2_LAST   = CNT_W'(MW2_LEN - 1);
    localparam logic [CNT_W-1:0] PROBE_LAST = CNT_W'(PROBE_LEN - 1);
    localparam logic [31:0]      SAMPLE_BEG = 32'(SAMPLE_DLY);
    localparam logic [31:0]      SAMPLE_END = 32'(SAMPLE_DLY + SAMPLE_LEN);

    pop_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] last_cnt;
    logic             phase_done;
    logic             count_inc;
    logic [31:0]      cnt_next_w;
    logic [15:0]      cycle_cnt_q;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        last_cnt   = '0;
        state_next = state;
        case (state)
            ST_PUMP:  last_cnt = PUMP_LAST;
            ST_WAIT:  last_cnt = WAIT_LAST;
            ST_MW1:   last_cnt = MW1_LAST;
            ST_FREE:  last_cnt = FREE_LAST;
            ST_MW2:   last_cnt = MW2_LAST;
            ST_PROBE: last_cnt = PROBE_LAST;
            default:  last_cnt = '0;
        endcase
        phase_done = (cnt == last_cnt);

        case (state)
            ST_IDLE:  if (enable)     state_next = ST_PUMP;
            ST_PUMP:  if (phase_done) state_next = ST_WAIT;
            ST_WAIT:  if (phase_done) state_next = ST_MW1;
            ST_MW1:   if (phase_done) state_next = ST_FREE;
            ST_FREE:  if (phase_done) state_next = ST_MW2;
            ST_MW2:   if (phase_done) state_next = ST_PROBE;
            ST_PROBE: if (phase_done) state_next = enable ? ST_PUMP : ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase

        // Every transition, including PROBE -> PUMP, lands on a new phase, so clear on change.
        if (state_next != state || state_next == ST_IDLE) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end

        cnt_next_w = 32'(cnt_next);
        count_inc  = (state == ST_PROBE) && phase_done;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock_2_5M or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pump        <= 1'b0;
            probe       <= 1'b0;
            MW          <= 1'b0;
            sample      <= 1'b0;
            cycle_start <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pump        <= (state_next == ST_PUMP);
            MW          <= (state_next == ST_MW1) || (state_next == ST_MW2);
            probe       <= (state_next == ST_PROBE);
            sample      <= (state_next == ST_PROBE) &&
                           (cnt_next_w >= SAMPLE_BEG) && (cnt_next_w < SAMPLE_END);
            cycle_start <= (state_next == ST_PUMP) && (state != ST_PUMP);
            if (count_inc) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_pop_cycle_sequencer.sv
// Directed bench for pop_cycle_sequencer with short phase lengths (23-tick period).
// A second instance with a long sample gate covers clipping at the end of PROBE.
`timescale 1ns/1ps
module tb_pop_cycle_sequencer;

    localparam int PERIOD = 23;
    localparam int PROBE0 = 17;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        en2;
    logic        pump, probe, mw, sample, busy, cycle_start;
    logic [15:0] cycle_count;
    logic        pump2, probe2, mw2, sample2, busy2, cycle_start2;
    logic [15:0] cycle_count2;

    int errors = 0;
    int checks = 0;

    always #200 clk = ~clk;

    pop_cycle_sequencer #(
        .CNT_W(16), .PUMP_LEN(4), .WAIT_LEN(2), .MW1_LEN(3), .FREE_LEN(5),
        .MW2_LEN(3), .PROBE_LEN(6), .SAMPLE_DLY(1), .SAMPLE_LEN(3)
    ) dut (
        .clock_2_5M(clk), .reset_n(reset_n), .enable(enable),
        .pump(pump), .probe(probe), .MW(mw), .sample(sample), .busy(busy),
        .cycle_start(cycle_start), .cycle_count(cycle_count)
    );

    pop_cycle_sequencer #(
        .CNT_W(16), .PUMP_LEN(4), .WAIT_LEN(2), .MW1_LEN(3), .FREE_LEN(5),
        .MW2_LEN(3), .PROBE_LEN(6), .SAMPLE_DLY(4), .SAMPLE_LEN(10)
    ) dut2 (
        .clock_2_5M(clk), .reset_n(reset_n), .enable(en2),
        .pump(pump2), .probe(probe2), .MW(mw2), .sample(sample2), .busy(busy2),
        .cycle_start(cycle_start2), .cycle_count(cycle_count2)
    );

    // Expected {pump, MW, probe, sample, cycle_start} at tick k of a cycle.
    function automatic logic [4:0] exp_bits(input int k, input int sdly, input int slen);
        logic p, m, pr, s, cs;
        p  = (k < 4);
        m  = (k >= 6 && k < 9) || (k >= 14 && k < 17);
        pr = (k >= PROBE0);
        s  = pr && ((k - PROBE0) >= sdly) && ((k - PROBE0) < sdly + slen);
        cs = (k == 0);
        return {p, m, pr, s, cs};
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b0;
        en2     = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pump, mw, probe, sample, cycle_start, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000", {pump, mw, probe, sample, cycle_start, busy});
        end
        checks++;
        if (cycle_count !== 16'd0 || cycle_count2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %h/%h want 0000/0000", cycle_count, cycle_count2);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pump, mw, probe, sample, cycle_start, busy} !== 6'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_enable: got %b busy2=%b want 000000/0",
                     {pump, mw, probe, sample, cycle_start, busy}, busy2);
        end
    endtask

    task automatic test_single_cycle;
        logic [4:0] got;
        enable = 1'b1;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            got = {pump, mw, probe, sample, cycle_start};
            checks++;
            if (got !== exp_bits(k, 1, 3) || busy !== 1'b1 || cycle_count !== 16'd0) begin
                errors++;
                $display("FAIL single_cycle t=%0d: got bits=%b busy=%b cnt=%0d want bits=%b busy=1 cnt=0",
                         k, got, busy, cycle_count, exp_bits(k, 1, 3));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] got;
        for (int c = 1; c <= 2; c++) begin
            for (int k = 0; k < PERIOD; k++) begin
                @(negedge clk);
                got = {pump, mw, probe, sample, cycle_start};
                checks++;
                if (got !== exp_bits(k, 1, 3) || busy !== 1'b1 || cycle_count !== 16'(c)) begin
                    errors++;
                    $display("FAIL back_to_back c=%0d t=%0d: got bits=%b busy=%b cnt=%0d want bits=%b busy=1 cnt=%0d",
                             c, k, got, busy, cycle_count, exp_bits(k, 1, 3), c);
                end
            end
        end
    endtask

    task automatic test_enable_drop;
        logic [4:0] got;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            got = {pump, mw, probe, sample, cycle_start};
            checks++;
            if (got !== exp_bits(k, 1, 3) || busy !== 1'b1 || cycle_count !== 16'd3) begin
                errors++;
                $display("FAIL enable_drop t=%0d: got bits=%b busy=%b cnt=%0d want bits=%b busy=1 cnt=3",
                         k, got, busy, cycle_count, exp_bits(k, 1, 3));
            end
            if (k == 7)  enable = 1'b0;
            if (k == 10) enable = 1'b1;
            if (k == 12) enable = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({pump, mw, probe, sample, cycle_start, busy} !== 6'b0 || cycle_count !== 16'd4) begin
                errors++;
                $display("FAIL enable_drop_idle i=%0d: got %b cnt=%0d want 000000 cnt=4",
                         i, {pump, mw, probe, sample, cycle_start, busy}, cycle_count);
            end
        end
    endtask

    task automatic test_sample_clip;
        logic [4:0] got;
        en2 = 1'b1;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            if (k == 0) en2 = 1'b0;
            got = {pump2, mw2, probe2, sample2, cycle_start2};
            checks++;
            if (got !== exp_bits(k, 4, 10) || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL sample_clip t=%0d: got bits=%b busy=%b want bits=%b busy=1",
                         k, got, busy2, exp_bits(k, 4, 10));
            end
        end
        @(negedge clk);
        checks++;
        if ({pump2, mw2, probe2, sample2, busy2} !== 5'b0 || cycle_count2 !== 16'd1) begin
            errors++;
            $display("FAIL sample_clip_end: got %b cnt=%0d want 00000 cnt=1",
                     {pump2, mw2, probe2, sample2, busy2}, cycle_count2);
        end
    endtask

    task automatic test_reset_mid;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) @(negedge clk);
        // Now in FREE (tick 11); pull reset between edges.
        #50 reset_n = 1'b0;
        #1;
        checks++;
        if ({pump, mw, probe, sample, cycle_start, busy} !== 6'b0 || cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b cnt=%0d want 000000 cnt=0",
                     {pump, mw, probe, sample, cycle_start, busy}, cycle_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pump !== 1'b1 || cycle_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart: got pump=%b cs=%b busy=%b want 1/1/1", pump, cycle_start, busy);
        end
    endtask

    task automatic test_wrap;
        logic [4:0] got;
        for (int k = 1; k < PERIOD; k++) begin
            @(negedge clk);
            if (k == 2) begin
                force dut.cycle_cnt_q = 16'hFFFF;
                #1;
                release dut.cycle_cnt_q;
            end
            if (k == 5) begin
                checks++;
                if (cycle_count !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL wrap_preload: got %h want ffff", cycle_count);
                end
            end
        end
        @(negedge clk);
        enable = 1'b0;
        checks++;
        if (cycle_count !== 16'h0000 || cycle_start !== 1'b1) begin
            errors++;
            $display("FAIL wrap_rollover: got cnt=%h cs=%b want 0000/1", cycle_count, cycle_start);
        end
        for (int k = 1; k < PERIOD; k++) begin
            @(negedge clk);
            got = {pump, mw, probe, sample, cycle_start};
            if (k == PROBE0 + 2) begin
                checks++;
                if (got !== exp_bits(k, 1, 3)) begin
                    errors++;
                    $display("FAIL wrap_cycle t=%0d: got %b want %b", k, got, exp_bits(k, 1, 3));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cycle_count !== 16'd1) begin
            errors++;
            $display("FAIL wrap_final: got busy=%b cnt=%0d want 0/1", busy, cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_enable_drop();
        test_sample_clip();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
